// File: rtl/hazard_ctrl.sv
// Issue/hazard controller: int/float pending-write scoreboard, FPU busy counter, stall/bubble/flush FSM.
// Optional macro WB_BYPASS_EN: a source cleared by a same-cycle WB commit is not a RAW hazard.
module hazard_ctrl #(
  parameter int FPU_LATENCY  = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_rs1_flt,
  input  logic             id_rs2_flt,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_int,
  input  logic             id_wr_flt,
  input  logic             id_fpu_op,
  input  logic             ex_branch_taken,
  input  logic             wb_wr_int,
  input  logic             wb_wr_flt,
  input  logic [4:0]       wb_rd,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             issue,
  output logic             fpu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int FW        = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam int FCW       = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  // The branch cycle itself raises flush, so the FLUSH state covers the remaining cycles.
  localparam int FL_LOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pend_int, pend_flt;
  logic [31:0]     clr_int, clr_flt, set_int, set_flt, rd_int, rd_flt;
  logic [FW-1:0]   fpu_ctr;
  logic [FCW-1:0]  fl_ctr;
  logic            raw, waw, structural, hazard, branch_go;

  assign fpu_busy = (fpu_ctr != '0);

  always_comb begin
    clr_int = wb_wr_int ? (32'd1 << wb_rd) : 32'd0;
    clr_flt = wb_wr_flt ? (32'd1 << wb_rd) : 32'd0;
    set_int = (issue && id_wr_int && id_rd != 5'd0) ? (32'd1 << id_rd) : 32'd0;
    set_flt = (issue && id_wr_flt) ? (32'd1 << id_rd) : 32'd0;
`ifdef WB_BYPASS_EN
    rd_int  = pend_int & ~clr_int;
    rd_flt  = pend_flt & ~clr_flt;
`else
    rd_int  = pend_int;
    rd_flt  = pend_flt;
`endif
    raw        = (id_use_rs1 && (id_rs1_flt ? rd_flt[id_rs1] : rd_int[id_rs1])) ||
                 (id_use_rs2 && (id_rs2_flt ? rd_flt[id_rs2] : rd_int[id_rs2]));
    waw        = (id_wr_int && pend_int[id_rd]) || (id_wr_flt && pend_flt[id_rd]);
    structural = id_fpu_op && fpu_busy;
    hazard     = id_valid && (raw || waw || structural);
  end

  // NOTE: every output and next-state gets a default before the case, so no latches are inferred.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    issue     = 1'b0;
    branch_go = 1'b0;
    if (rst) begin
      case (state)
        RUN, HOLD: begin
          if (ex_branch_taken) begin
            flush     = 1'b1;
            branch_go = 1'b1;
            state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (hazard) begin
            stall     = 1'b1;
            bubble    = 1'b1;
            state_nxt = HOLD;
          end else begin
            issue     = id_valid;
            state_nxt = RUN;
          end
        end
        FLUSH: begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (fl_ctr == '0) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: the scoreboard is a handful of flops, not a RAM, so it is cleared by reset like all other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_int  <= '0;
      pend_flt  <= '0;
      fpu_ctr   <= '0;
      fl_ctr    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      pend_int <= (pend_int & ~clr_int) | set_int;
      pend_flt <= (pend_flt & ~clr_flt) | set_flt;

      if (issue && id_fpu_op)  fpu_ctr <= FW'(FPU_LATENCY - 1);
      else if (fpu_busy)       fpu_ctr <= fpu_ctr - 1'b1;

      if (branch_go)                           fl_ctr <= FCW'(FL_LOAD_I);
      else if (state == FLUSH && fl_ctr != '0) fl_ctr <= fl_ctr - 1'b1;

      if (stall && !(&stall_cnt))     stall_cnt <= stall_cnt + 1'b1;
      if (branch_go && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Expected output vector order: {stall, bubble, flush, issue, fpu_busy}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_ISS  = 5'b00010;
  localparam logic [4:0] O_STL  = 5'b11000;
  localparam logic [4:0] O_STLB = 5'b11001;
  localparam logic [4:0] O_BUSY = 5'b00001;
  localparam logic [4:0] O_FL   = 5'b00100;
  localparam logic [4:0] O_FLB  = 5'b01100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, id_rs1_flt, id_rs2_flt;
  logic id_wr_int, id_wr_flt, id_fpu_op, ex_branch_taken, wb_wr_int, wb_wr_flt;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic stall, bubble, flush, issue, fpu_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.FPU_LATENCY(4), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_flt(id_rs1_flt), .id_rs2_flt(id_rs2_flt),
    .id_rd(id_rd), .id_wr_int(id_wr_int), .id_wr_flt(id_wr_flt), .id_fpu_op(id_fpu_op),
    .ex_branch_taken(ex_branch_taken),
    .wb_wr_int(wb_wr_int), .wb_wr_flt(wb_wr_flt), .wb_rd(wb_rd),
    .stall(stall), .bubble(bubble), .flush(flush), .issue(issue), .fpu_busy(fpu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [4:0]       o;
    bit               chk_cnt;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({stall, bubble, flush, issue, fpu_busy} !== e.o) begin
        failures++;
        $display("FAIL %s: stall/bubble/flush/issue/busy=%b expected %b", e.nm,
                 {stall, bubble, flush, issue, fpu_busy}, e.o);
      end
      if (e.chk_cnt) begin
        checks++;
        if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          failures++;
          $display("FAIL %s_cnt: stall_cnt=%0d flush_cnt=%0d expected %0d %0d", e.nm,
                   stall_cnt, flush_cnt, e.sc, e.fc);
        end
      end
    end
  end

  task automatic clr_in();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rs1_flt = 1'b0; id_rs2_flt = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rd = 5'd0; id_wr_int = 1'b0; id_wr_flt = 1'b0; id_fpu_op = 1'b0;
    ex_branch_taken = 1'b0; wb_wr_int = 1'b0; wb_wr_flt = 1'b0; wb_rd = 5'd0;
  endtask

  // Queue the expectation for the current cycle, advance one clock, return to idle inputs.
  task automatic cyc(input string nm, input logic [4:0] o,
                     input bit cc = 1'b0, input int sc = 0, input int fc = 0);
    exp_t e;
    e.nm = nm; e.o = o; e.chk_cnt = cc; e.sc = CNT_W'(sc); e.fc = CNT_W'(fc);
    q.push_back(e);
    @(posedge clk); #1;
    clr_in();
  endtask

  task automatic wr(input logic [4:0] rd, input bit flt, input bit fpu);
    id_valid = 1'b1; id_rd = rd; id_wr_int = !flt; id_wr_flt = flt; id_fpu_op = fpu;
  endtask

  task automatic rd1(input logic [4:0] rs, input bit flt);
    id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = rs; id_rs1_flt = flt;
  endtask

  task automatic rd2(input logic [4:0] rs, input bit flt);
    id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = rs; id_rs2_flt = flt;
  endtask

  task automatic wb(input logic [4:0] rd, input bit flt);
    wb_wr_int = !flt; wb_wr_flt = flt; wb_rd = rd;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    @(posedge clk); #1;

    // Reset held: a writing instruction in ID must not issue, counters at zero.
    wr(5'd3, 1'b0, 1'b0);
    cyc("reset", O_IDLE, 1'b1, 0, 0);
    rst = 1'b1;

    // RAW on x5, released by WB commit.
    wr(5'd5, 1'b0, 1'b0);           cyc("raw_issue", O_ISS);
    rd1(5'd5, 1'b0);                cyc("raw_stall1", O_STL);
    rd1(5'd5, 1'b0);                cyc("raw_stall2", O_STL);
    rd1(5'd5, 1'b0); wb(5'd5, 1'b0); cyc("raw_commit", BYP ? O_ISS : O_STL);
    rd1(5'd5, 1'b0);                cyc("raw_after", O_ISS);

    // x0 is never tracked.
    wr(5'd0, 1'b0, 1'b0);           cyc("x0_write", O_ISS);
    rd1(5'd0, 1'b0);                cyc("x0_read", O_ISS);

    // Same-cycle set and clear of x7: set wins.
    wr(5'd7, 1'b0, 1'b0); wb(5'd7, 1'b0); cyc("set_wins_issue", O_ISS);
    rd1(5'd7, 1'b0);                      cyc("set_wins_stall", O_STL);
    rd1(5'd7, 1'b0); wb(5'd7, 1'b0);      cyc("set_wins_commit", BYP ? O_ISS : O_STL);
    rd1(5'd7, 1'b0);                      cyc("set_wins_after", O_ISS, 1'b1, BYP ? 3 : 5, 0);

    // Back-to-back FPU ops: second stalls 3 cycles on the busy FPU.
    wr(5'd1, 1'b1, 1'b1);           cyc("fpu_a", O_ISS);
    wr(5'd2, 1'b1, 1'b1);           cyc("fpu_b_stall1", O_STLB);
    wr(5'd2, 1'b1, 1'b1);           cyc("fpu_b_stall2", O_STLB);
    wr(5'd2, 1'b1, 1'b1);           cyc("fpu_b_stall3", O_STLB);
    wr(5'd2, 1'b1, 1'b1);           cyc("fpu_b_issue", O_ISS);
    cyc("fpu_busy1", O_BUSY);
    cyc("fpu_busy2", O_BUSY);
    cyc("fpu_busy3", O_BUSY);
    cyc("fpu_idle", O_IDLE, 1'b1, BYP ? 6 : 8, 0);

    // WAW on float f1 (pending from fpu_a); commit clears it for the next cycle.
    wr(5'd1, 1'b1, 1'b0);                 cyc("waw_stall", O_STL);
    wr(5'd1, 1'b1, 1'b0); wb(5'd1, 1'b1); cyc("waw_commit", O_STL);
    wr(5'd1, 1'b1, 1'b0);                 cyc("waw_release", O_ISS, 1'b1, BYP ? 8 : 10, 0);

    // Taken branch during a RAW stall on x9 (read through rs2).
    wr(5'd9, 1'b0, 1'b0);                       cyc("br_issue", O_ISS);
    rd2(5'd9, 1'b0);                            cyc("br_stall", O_STL);
    rd2(5'd9, 1'b0); ex_branch_taken = 1'b1;    cyc("br_flush1", O_FL);
    rd2(5'd9, 1'b0); ex_branch_taken = 1'b1;    cyc("br_flush2", O_FLB);
    rd2(5'd9, 1'b0);                            cyc("br_pend_kept", O_STL, 1'b1, BYP ? 9 : 11, 1);
    rd2(5'd9, 1'b0); wb(5'd9, 1'b0);            cyc("br_commit", BYP ? O_ISS : O_STL);
    rd2(5'd9, 1'b0);                            cyc("br_after", O_ISS, 1'b1, BYP ? 10 : 13, 1);

    // Asynchronous reset while in HOLD.
    wr(5'd11, 1'b0, 1'b0);          cyc("rst_issue", O_ISS);
    rd1(5'd11, 1'b0);               cyc("rst_hold", O_STL);
    rd1(5'd11, 1'b0); rst = 1'b0;   cyc("rst_async", O_IDLE, 1'b1, 0, 0);
    rst = 1'b1;
    rd1(5'd11, 1'b0);               cyc("rst_pend_clr", O_ISS, 1'b1, 0, 0);

    // Stall counter saturation: hold a RAW stall for more than 2^CNT_W cycles.
    wr(5'd12, 1'b0, 1'b0);          cyc("sat_issue", O_ISS);
    rd1(5'd12, 1'b0);
    repeat (65540) begin @(posedge clk); #1; end
    cyc("sat_hold", O_STL, 1'b1, 65535, 0);
    rd1(5'd12, 1'b0);               cyc("sat_nowrap", O_STL, 1'b1, 65535, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
